// File: rtl/chip8_pkg.sv
// Shared CHIP-8 keypad constants: matrix geometry, row FSM states and the physical-to-CHIP-8 keymap.
// KEYPAD_CHIP8_MAP_EN selects the CHIP-8 layout remap in key_index(); undefined keeps index r*4+c.
package chip8_pkg;

  localparam int unsigned KEY_COUNT = 16;
  localparam int unsigned ROWS      = 4;
  localparam int unsigned COLS      = 4;

  typedef logic [3:0] key_idx_t;

  localparam logic [1:0] ROW0 = 2'd0;
  localparam logic [1:0] ROW1 = 2'd1;
  localparam logic [1:0] ROW2 = 2'd2;
  localparam logic [1:0] ROW3 = 2'd3;

  // Physical position r*4+c -> CHIP-8 key, rows "1 2 3 C / 4 5 6 D / 7 8 9 E / A 0 B F"
  localparam key_idx_t KEYMAP [KEY_COUNT] = '{
    4'h1, 4'h2, 4'h3, 4'hC,
    4'h4, 4'h5, 4'h6, 4'hD,
    4'h7, 4'h8, 4'h9, 4'hE,
    4'hA, 4'h0, 4'hB, 4'hF
  };

  function automatic key_idx_t key_index(input key_idx_t phys);
`ifdef KEYPAD_CHIP8_MAP_EN
    return KEYMAP[phys];
`else
    return phys;
`endif
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key's debounce: stable state plus a run counter of consecutive disagreeing samples.
// `rose` is combinational so the parent can register the press event on the same edge as `stable`.
module key_debounce #(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_en,
  input  logic sample,
  output logic stable,
  output logic rose
);

  localparam int unsigned CW = $clog2(DEBOUNCE_SCANS) + 1;

  logic [CW-1:0] cnt;
  logic          at_limit;

  assign at_limit = (cnt == CW'(DEBOUNCE_SCANS - 1));
  assign rose     = sample_en && sample && !stable && at_limit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (sample_en) begin
      if (sample == stable) begin
        cnt <= '0;
      end else if (at_limit) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column synchroniser, row FSM with settle counter, 16 debouncers, remap and press encode.
// Define KEYPAD_CHIP8_MAP_EN to report keys in the CHIP-8 layout instead of r*4+c.
module keypad_scanner
  import chip8_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 25_000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [ROWS-1:0]      row_n,
  input  logic [COLS-1:0]      col_n,
  output logic [KEY_COUNT-1:0] keys,
  output logic                 key_pressed,
  output logic [3:0]           key_code
);

  localparam int unsigned SW = $clog2(SCAN_DIV);

  logic [COLS-1:0]      col_meta;
  logic [COLS-1:0]      col_sync;
  logic [1:0]           row;
  logic [1:0]           row_next;
  logic [SW-1:0]        settle;
  logic                 sample_en;
  logic [KEY_COUNT-1:0] phys_stable;
  logic [KEY_COUNT-1:0] phys_rose;
  logic [KEY_COUNT-1:0] rose_map;
  logic                 any_rose;
  key_idx_t             first_code;

  // Columns idle high (pull-ups), so the synchroniser resets to all ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= col_n;
      col_sync <= col_meta;
    end
  end

  assign sample_en = (settle == SW'(SCAN_DIV - 1));

  always_comb begin
    row_next = ROW0;
    case (row)
      ROW0:    row_next = ROW1;
      ROW1:    row_next = ROW2;
      ROW2:    row_next = ROW3;
      ROW3:    row_next = ROW0;
      default: row_next = ROW0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row    <= ROW0;
      settle <= '0;
    end else if (sample_en) begin
      row    <= row_next;
      settle <= '0;
    end else begin
      settle <= settle + SW'(1);
    end
  end

  assign row_n = ~(4'b0001 << row);

  for (genvar p = 0; p < KEY_COUNT; p++) begin : g_key
    key_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
      .clk      (clk),
      .reset    (reset),
      .sample_en(sample_en && (row == 2'(p / COLS))),
      .sample   (~col_sync[p % COLS]),
      .stable   (phys_stable[p]),
      .rose     (phys_rose[p])
    );
  end

  always_comb begin
    keys     = '0;
    rose_map = '0;
    for (int unsigned p = 0; p < KEY_COUNT; p++) begin
      keys[key_index(key_idx_t'(p))]     = phys_stable[p];
      rose_map[key_index(key_idx_t'(p))] = phys_rose[p];
    end
  end

  // Scan from the top down so the lowest mapped index wins when several rise together
  always_comb begin
    first_code = '0;
    for (int unsigned i = KEY_COUNT; i > 0; i--) begin
      if (rose_map[i-1]) first_code = key_idx_t'(i - 1);
    end
  end

  assign any_rose = |rose_map;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_pressed <= 1'b0;
      key_code    <= '0;
    end else begin
      key_pressed <= any_rose;
      if (any_rose) key_code <= first_code;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a physical key-matrix model drives col_n from row_n,
// and a per-key disagreement-run reference model predicts keys / key_pressed / key_code every clock.
module tb_keypad_scanner;

  localparam int unsigned SD = 4;
  localparam int unsigned DS = 3;

`ifdef KEYPAD_CHIP8_MAP_EN
  localparam logic [15:0] K00 = 16'h0002;
  localparam logic [3:0]  C00 = 4'd1;
  localparam logic [15:0] K2  = 16'h4100;
  localparam logic [3:0]  C2  = 4'd8;
`else
  localparam logic [15:0] K00 = 16'h0001;
  localparam logic [3:0]  C00 = 4'd0;
  localparam logic [15:0] K2  = 16'h0A00;
  localparam logic [3:0]  C2  = 4'd9;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [15:0] keys;
  logic        key_pressed;
  logic [3:0]  key_code;

  keypad_scanner #(
    .SCAN_DIV      (SD),
    .DEBOUNCE_SCANS(DS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .row_n      (row_n),
    .col_n      (col_n),
    .keys       (keys),
    .key_pressed(key_pressed),
    .key_code   (key_code)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          pulses;
  int          n;
  bit          pressed  [16];
  bit          m_stable [16];
  int          m_run    [16];
  logic [15:0] exp_keys;
  logic        exp_kp;
  logic [3:0]  exp_kc;
  logic [3:0]  exp_row;

  function automatic int map_key(input int p);
`ifdef KEYPAD_CHIP8_MAP_EN
    int t [16] = '{1, 2, 3, 12, 4, 5, 6, 13, 7, 8, 9, 14, 10, 0, 11, 15};
    return t[p];
`else
    return p;
`endif
  endfunction

  // Physical matrix: a held key shorts its column to the currently driven row
  task automatic drive_cols();
    logic [3:0] c_v;
    c_v = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (row_n[r] === 1'b0 && pressed[r*4+c]) c_v[c] = 1'b0;
    col_n = c_v;
  endtask

  task automatic model_clear();
    for (int p = 0; p < 16; p++) begin
      m_stable[p] = 1'b0;
      m_run[p]    = 0;
    end
    n        = 0;
    exp_keys = '0;
    exp_kp   = 1'b0;
    exp_kc   = '0;
    exp_row  = 4'b1110;
    pulses   = 0;
  endtask

  task automatic do_reset(input bit clear_keys);
    @(negedge clk);
    reset = 1'b0;
    if (clear_keys) for (int p = 0; p < 16; p++) pressed[p] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_clear();
    drive_cols();
  endtask

  // Advance one clock; every SD-th clock one row is sampled, rows visited in order
  task automatic tick();
    bit any;
    int rmin;
    int r;
    int p;
    @(posedge clk);
    any  = 1'b0;
    rmin = 16;
    if (n % SD == SD - 1) begin
      r = (n / SD) % 4;
      for (int c = 0; c < 4; c++) begin
        p = r * 4 + c;
        if (pressed[p] == m_stable[p]) m_run[p] = 0;
        else begin
          m_run[p]++;
          if (m_run[p] >= DS) begin
            m_stable[p] = !m_stable[p];
            m_run[p]    = 0;
            if (m_stable[p]) begin
              any = 1'b1;
              if (map_key(p) < rmin) rmin = map_key(p);
            end
          end
        end
      end
    end
    exp_kp = any;
    if (any) exp_kc = 4'(rmin);
    exp_keys = '0;
    for (int k = 0; k < 16; k++) if (m_stable[k]) exp_keys[map_key(k)] = 1'b1;
    n++;
    exp_row = ~(4'b0001 << ((n / SD) % 4));
    #1;
    drive_cols();
    if (key_pressed === 1'b1) pulses++;
  endtask

  task automatic test_reset();
    logic [3:0] seq [4];
    seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    do_reset(1'b1);
    pressed[0] = 1'b1;
    drive_cols();
    repeat (16 * 4 + 6) tick();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (row_n !== 4'b1110) begin errors++; $display("FAIL reset_row_n got %b want 1110", row_n); end
    checks++;
    if (keys !== 16'h0000) begin errors++; $display("FAIL reset_keys got %h want 0000", keys); end
    checks++;
    if (key_pressed !== 1'b0) begin errors++; $display("FAIL reset_key_pressed got %b want 0", key_pressed); end
    checks++;
    if (key_code !== 4'd0) begin errors++; $display("FAIL reset_key_code got %0d want 0", key_code); end
    pressed[0] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_clear();
    drive_cols();
    for (int t = 1; t <= 20; t++) begin
      tick();
      checks++;
      if (row_n !== seq[(t / SD) % 4] || keys !== 16'h0000 || key_pressed !== 1'b0) begin
        errors++;
        $display("FAIL row_walk t=%0d got row_n=%b keys=%h kp=%b want row_n=%b keys=0000 kp=0",
                 t, row_n, keys, key_pressed, seq[(t / SD) % 4]);
      end
    end
  endtask

  task automatic test_hold_single();
    do_reset(1'b1);
    pressed[0] = 1'b1;
    drive_cols();
    for (int t = 0; t < 80; t++) begin
      tick();
      checks++;
      if ({row_n, keys, key_pressed, key_code} !== {exp_row, exp_keys, exp_kp, exp_kc}) begin
        errors++;
        $display("FAIL hold_model t=%0d got row=%b keys=%h kp=%b kc=%0d want row=%b keys=%h kp=%b kc=%0d",
                 t, row_n, keys, key_pressed, key_code, exp_row, exp_keys, exp_kp, exp_kc);
      end
      if (t == 34) begin
        checks++;
        if (keys !== 16'h0000) begin errors++; $display("FAIL hold_before_3rd got %h want 0000", keys); end
      end
      if (t == 35) begin
        checks++;
        if (keys !== K00 || key_pressed !== 1'b1 || key_code !== C00) begin
          errors++;
          $display("FAIL hold_after_3rd got keys=%h kp=%b kc=%0d want keys=%h kp=1 kc=%0d",
                   keys, key_pressed, key_code, K00, C00);
        end
      end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL hold_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_glitch();
    do_reset(1'b1);
    pressed[6] = 1'b1;
    drive_cols();
    for (int t = 0; t < 80; t++) begin
      if (t == 32) begin
        pressed[6] = 1'b0;
        drive_cols();
      end
      tick();
      checks++;
      if ({row_n, keys, key_pressed, key_code} !== {exp_row, exp_keys, exp_kp, exp_kc}) begin
        errors++;
        $display("FAIL glitch_model t=%0d got keys=%h kp=%b kc=%0d want keys=%h kp=%b kc=%0d",
                 t, keys, key_pressed, key_code, exp_keys, exp_kp, exp_kc);
      end
    end
    checks++;
    if (keys !== 16'h0000 || pulses != 0) begin
      errors++;
      $display("FAIL glitch_final got keys=%h pulses=%0d want keys=0000 pulses=0", keys, pulses);
    end
  endtask

  task automatic test_two_keys();
    do_reset(1'b1);
    pressed[9]  = 1'b1;
    pressed[11] = 1'b1;
    drive_cols();
    for (int t = 0; t < 128; t++) begin
      if (t == 64) begin
        checks++;
        if (keys !== K2 || key_code !== C2 || pulses != 1) begin
          errors++;
          $display("FAIL two_keys_held got keys=%h kc=%0d pulses=%0d want keys=%h kc=%0d pulses=1",
                   keys, key_code, pulses, K2, C2);
        end
        pressed[9]  = 1'b0;
        pressed[11] = 1'b0;
        drive_cols();
      end
      tick();
      checks++;
      if ({row_n, keys, key_pressed, key_code} !== {exp_row, exp_keys, exp_kp, exp_kc}) begin
        errors++;
        $display("FAIL two_keys_model t=%0d got keys=%h kp=%b kc=%0d want keys=%h kp=%b kc=%0d",
                 t, keys, key_pressed, key_code, exp_keys, exp_kp, exp_kc);
      end
    end
    checks++;
    if (keys !== 16'h0000 || pulses != 1 || key_code !== C2) begin
      errors++;
      $display("FAIL two_keys_release got keys=%h pulses=%0d kc=%0d want keys=0000 pulses=1 kc=%0d",
               keys, pulses, key_code, C2);
    end
  endtask

  task automatic test_reset_counter();
    do_reset(1'b1);
    pressed[5] = 1'b1;
    drive_cols();
    repeat (32) tick();
    do_reset(1'b0);
    for (int t = 0; t < 48; t++) begin
      tick();
      checks++;
      if ({row_n, keys, key_pressed, key_code} !== {exp_row, exp_keys, exp_kp, exp_kc}) begin
        errors++;
        $display("FAIL rst_cnt_model t=%0d got keys=%h kp=%b kc=%0d want keys=%h kp=%b kc=%0d",
                 t, keys, key_pressed, key_code, exp_keys, exp_kp, exp_kc);
      end
      if (t == 38) begin
        checks++;
        if (keys !== 16'h0000) begin errors++; $display("FAIL rst_cnt_before got %h want 0000", keys); end
      end
      if (t == 39) begin
        checks++;
        if (keys !== 16'h0020 || key_pressed !== 1'b1 || key_code !== 4'd5) begin
          errors++;
          $display("FAIL rst_cnt_after got keys=%h kp=%b kc=%0d want keys=0020 kp=1 kc=5",
                   keys, key_pressed, key_code);
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset(1'b1);
    for (int s = 0; s < 40; s++) begin
      for (int p = 0; p < 16; p++)
        if ($urandom_range(3) == 0) pressed[p] = !pressed[p];
      drive_cols();
      for (int t = 0; t < 16; t++) begin
        tick();
        checks++;
        if ({row_n, keys, key_pressed, key_code} !== {exp_row, exp_keys, exp_kp, exp_kc}) begin
          errors++;
          $display("FAIL random_model s=%0d t=%0d got row=%b keys=%h kp=%b kc=%0d want row=%b keys=%h kp=%b kc=%0d",
                   s, t, row_n, keys, key_pressed, key_code, exp_row, exp_keys, exp_kp, exp_kc);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    col_n = '1;
    for (int p = 0; p < 16; p++) pressed[p] = 1'b0;
    model_clear();
    test_reset();
    test_hold_single();
    test_glitch();
    test_two_keys();
    test_reset_counter();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 hex matrix keypad, synchronises and debounces each key, and presents a stable 16-bit key mask to `chip8_cpu` on its `keys` input. It also produces a one-cycle new-press event with the key code, which the CPU uses for the wait-for-key instruction. It sits between the board keypad pins and the CPU.

## Interface
- `SCAN_DIV`, default 25_000: clocks each row is driven before its columns are sampled. Minimum 4.
- `DEBOUNCE_SCANS`, default 4: consecutive disagreeing samples of a key required to change its stable state. Minimum 1.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `row_n` out 4: row drive, active low. Exactly one bit is low at any time.
- `col_n` in 4: column sense, active low, externally pulled up, asynchronous to `clk`.
- `keys` out 16: debounced key mask. Bit i is 1 while CHIP-8 key i is held.
- `key_pressed` out 1: one-cycle pulse on a debounced 0->1 transition.
- `key_code` out 4: key index reported with the last `key_pressed`. Held between pulses.

## Operation
- `col_n` passes through a 2-FF synchroniser before use.
- The row FSM has four states, ROW0 to ROW3, each driving `row_n` = ~(1<<r).
  - A settle counter runs from 0 to SCAN_DIV-1.
  - At count SCAN_DIV-1, the synchronised columns are sampled: raw[r*4+c] = ~col_sync[c]. The FSM then advances r -> (r+1) mod 4 and clears the counter.
- Per key, there is a counter of width clog2(DEBOUNCE_SCANS)+1, updated only when that key's row is sampled:
  - If the sample equals the stable state, the counter clears.
  - If the sample differs and counter == DEBOUNCE_SCANS-1, the stable state toggles and the counter clears.
  - Otherwise the counter increments.
- When several keys of one row become pressed on the same sample, `key_pressed` fires once and `key_code` is the lowest index among them. The other keys still appear in `keys`.
- Releases update `keys` but never pulse `key_pressed`.
- Reset values: `row_n`=4'b1110, `keys`=0, `key_pressed`=0, `key_code`=0, all counters 0, FSM in ROW0.
- Reset asserted mid-scan returns everything to these reset values immediately. No event is emitted on release of reset.

## Timing
- A full scan takes 4*SCAN_DIV clocks. Each key is sampled once per scan.
- Sample-to-`keys` latency is 1 clock: `keys` updates on the edge after the sample cycle. `key_pressed`/`key_code` are registered in the same cycle as that `keys` update.
- A press stable from scan k is reflected in `keys` after DEBOUNCE_SCANS samples of that key. Worst case is (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 3 clocks from the physical edge.
- A glitch shorter than DEBOUNCE_SCANS consecutive samples never changes `keys`.
- The synchroniser delay of 2 clocks is absorbed because SCAN_DIV >= 4.

## Configuration
- `KEYPAD_CHIP8_MAP_EN` defined: physical position (r,c) is remapped to the CHIP-8 layout, rows "1 2 3 C / 4 5 6 D / 7 8 9 E / A 0 B F". For example, (0,0)->key 1, (3,1)->key 0, (3,3)->key F.
- Undefined: key index = r*4+c, with no remap. `key_code` follows the same mapping as `keys`.

## Structure
- Shared package `chip8_pkg` holds:
  - KEY_COUNT=16 and ROWS=COLS=4.
  - The 16-entry physical-to-CHIP-8 keymap constant, also used by the CPU bench models.
- Sub-module `key_debounce` holds one key's counter and stable-state register, with a sample-strobe input and a rose output. It is instantiated 16 times.
- The top holds the synchroniser, row FSM, settle counter, remap and lowest-index priority encode.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_SCANS=3.
- Reset held low mid-scan -> `row_n`=1110, `keys`=0, `key_pressed`=0. After release, `row_n` steps 1110->1101->1011->0111->1110 every 4 clocks.
- Hold (0,0) low for 5 scans, with the macro defined -> `keys`=16'h0002 after the 3rd sample. One `key_pressed` pulse with `key_code`=1. No further pulses while held.
- Same press with the macro undefined -> `keys`=16'h0001 and `key_code`=0.
- Press (1,2) for 2 samples, then release -> `keys` stays 0 and no pulse.
- Press (2,1) and (2,3) on the same scan, macro undefined -> `keys`=16'h0A00 and a single pulse with `key_code`=9. Release both -> `keys`=0 after 3 samples, with no pulse.
- Assert reset while a key counter is at 2 -> after release, 3 fresh samples are needed before `keys` changes.
